brick_field: RTL

BRICK_FIELD -- requirements
Module: brick_field

---
 rtl/brick_pkg.sv | 36 +++
 rtl/brick_layout_rom.sv | 37 +++
 rtl/brick_field.sv | 137 +++++++++++++
 3 files changed

// File: rtl/brick_pkg.sv
// Shared constants, direction encodings, state enum and map-row helpers for the brick field.
package brick_pkg;

  localparam int unsigned MAP_ROWS    = 30;
  localparam int unsigned MAP_COLS    = 40;
  localparam int unsigned CELL_SHIFT  = 4;
  localparam int unsigned BULLET_STEP = 4;
  localparam int unsigned BULLET_SIZE = 8;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned LEFT_W  = 11;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned CELL_W  = 6;
  localparam int unsigned LEVEL_W = 2;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [MAP_COLS-1:0] map_row_t;

  // Column c lives at bit (MAP_COLS-1-c); off-map columns give an empty mask.
  function automatic map_row_t col_bit(input logic [CELL_W-1:0] col);
    map_row_t m;
    m = '0;
    if (col < CELL_W'(MAP_COLS)) m[CELL_W'(MAP_COLS - 1) - col] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/brick_layout_rom.sv
// Combinational level layout table: (level,row) -> brick row, plus a steel row
// when BRICK_FIELD_STEEL_EN is defined.
module brick_layout_rom
  import brick_pkg::*;
(
  input  logic [LEVEL_W-1:0] level,
  input  logic [ROW_W-1:0]   row,
  output map_row_t           brick_row
`ifdef BRICK_FIELD_STEEL_EN
  ,
  output map_row_t           steel_row
`endif
);

  always_comb begin
    brick_row = '0;
    case (level)
      2'd0: if (row == 5'd10 || row == 5'd11) brick_row = 40'h00_3FFF_FC00;
      2'd1: if (row >= 5'd2 && row <= 5'd27 && !row[0]) brick_row = 40'hF0_F0F0_F0F0;
      2'd2: if (row <= 5'd29 && row[0]) brick_row = 40'hAA_AAAA_AAAA;
      default: brick_row = '0;
    endcase
  end

`ifdef BRICK_FIELD_STEEL_EN
  // Steel never overlaps a brick cell in any level.
  always_comb begin
    steel_row = '0;
    case (level)
      2'd0: if (row == 5'd20) steel_row = 40'h00_003C_0000;
      2'd1: if (row == 5'd15) steel_row = 40'h80_0000_0001;
      default: steel_row = '0;
    endcase
  end
`endif

endmodule

// File: rtl/brick_field.sv
// Brick occupancy map: loads a level one row per frame_clk, then clears bricks hit
// by the bullet's next-step box. Optional indestructible steel via BRICK_FIELD_STEEL_EN.
module brick_field
  import brick_pkg::*;
(
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                level_load,
  input  logic [LEVEL_W-1:0]  level_sel,
  input  logic                bullet_active,
  input  logic [COORD_W-1:0]  bullet_x,
  input  logic [COORD_W-1:0]  bullet_y,
  input  logic [3:0]          bullet_dir,
  output logic [MAP_COLS-1:0] brick_map [0:MAP_ROWS-1],
  output logic [LEFT_W-1:0]   bricks_left,
  output logic                hit_pulse,
  output logic                busy
);

  localparam logic [COORD_W-1:0] STEP_POS = COORD_W'(BULLET_STEP);
  localparam logic [COORD_W-1:0] STEP_NEG = COORD_W'(0) - STEP_POS;
  localparam logic [COORD_W-1:0] BOX_EXT  = COORD_W'(BULLET_SIZE - 1);

  state_t             state, state_nxt;
  logic [ROW_W-1:0]   load_row;
  logic [LEVEL_W-1:0] level;
  map_row_t           brick_plane [0:MAP_ROWS-1];
  map_row_t           rom_brick;
`ifdef BRICK_FIELD_STEEL_EN
  map_row_t           steel_plane [0:MAP_ROWS-1];
  map_row_t           rom_steel;
`endif

  logic [COORD_W-1:0] dx, dy, px, py, px_far, py_far;
  logic [CELL_W-1:0]  row_a, row_b, col_a, col_b;
  logic [ROW_W-1:0]   idx_a, idx_b;
  logic               row_a_ok, row_b_ok;
  map_row_t           col_mask, hit_a, hit_b;
  logic [2:0]         hit_cnt;

  brick_layout_rom u_rom (
    .level     (level),
    .row       (load_row),
    .brick_row (rom_brick)
`ifdef BRICK_FIELD_STEEL_EN
    ,
    .steel_row (rom_steel)
`endif
  );

  always_ff @(posedge frame_clk) begin
    if (Reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (level_load)                                           state_nxt = LOAD;
    else if (state == LOAD && load_row == ROW_W'(MAP_ROWS-1)) state_nxt = RUN;
  end

  always_comb begin
    busy = 1'b0;
    if (state == LOAD) busy = 1'b1;
    for (int i = 0; i < MAP_ROWS; i++) begin
`ifdef BRICK_FIELD_STEEL_EN
      brick_map[i] = brick_plane[i] | steel_plane[i];
`else
      brick_map[i] = brick_plane[i];
`endif
    end
  end

  // Predicted bullet box one step ahead; rows/cols past the map (incl. wrapped negatives) drop out.
  always_comb begin
    dx = '0;
    dy = '0;
    case (bullet_dir)
      DIR_UP:    dy = STEP_NEG;
      DIR_DOWN:  dy = STEP_POS;
      DIR_LEFT:  dx = STEP_NEG;
      DIR_RIGHT: dx = STEP_POS;
      default: ;
    endcase
    px       = bullet_x + dx;
    py       = bullet_y + dy;
    px_far   = px + BOX_EXT;
    py_far   = py + BOX_EXT;
    row_a    = CELL_W'(py >> CELL_SHIFT);
    row_b    = CELL_W'(py_far >> CELL_SHIFT);
    col_a    = CELL_W'(px >> CELL_SHIFT);
    col_b    = CELL_W'(px_far >> CELL_SHIFT);
    row_a_ok = row_a < CELL_W'(MAP_ROWS);
    row_b_ok = row_b < CELL_W'(MAP_ROWS) && row_b != row_a;
    idx_a    = row_a_ok ? row_a[ROW_W-1:0] : '0;
    idx_b    = row_b_ok ? row_b[ROW_W-1:0] : '0;
    col_mask = col_bit(col_a) | col_bit(col_b);
    hit_a    = row_a_ok ? (brick_plane[idx_a] & col_mask) : '0;
    hit_b    = row_b_ok ? (brick_plane[idx_b] & col_mask) : '0;
    hit_cnt  = 3'($countones(hit_a)) + 3'($countones(hit_b));
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      for (int i = 0; i < MAP_ROWS; i++) begin
        brick_plane[i] <= '0;
`ifdef BRICK_FIELD_STEEL_EN
        steel_plane[i] <= '0;
`endif
      end
      load_row    <= '0;
      level       <= '0;
      bricks_left <= '0;
      hit_pulse   <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      if (level_load) begin
        level       <= level_sel;
        load_row    <= '0;
        bricks_left <= '0;
      end else if (state == LOAD) begin
        brick_plane[load_row] <= rom_brick;
`ifdef BRICK_FIELD_STEEL_EN
        steel_plane[load_row] <= rom_steel;
`endif
        bricks_left <= bricks_left + LEFT_W'($countones(rom_brick));
        load_row    <= load_row + ROW_W'(1);
      end else if (bullet_active && hit_cnt != 3'd0) begin
        if (row_a_ok) brick_plane[idx_a] <= brick_plane[idx_a] & ~col_mask;
        if (row_b_ok) brick_plane[idx_b] <= brick_plane[idx_b] & ~col_mask;
        hit_pulse   <= 1'b1;
        bricks_left <= (bricks_left > LEFT_W'(hit_cnt)) ? bricks_left - LEFT_W'(hit_cnt) : '0;
      end
    end
  end

endmodule
